// File: rtl/ycbcr_stream_packer_pkg.sv
// rtl/ycbcr_stream_packer_pkg.sv - shared word layout, lane offsets, frame geometry and FSM states
package ycbcr_stream_packer_pkg;

   localparam int DSIZE  = 36;
   localparam int SB_SOF = 32;
   localparam int SB_EOF = 33;
   localparam int SB_SOL = 34;
   localparam int SB_EOL = 35;

   localparam logic [1:0] LANE_Y0 = 2'd0;
   localparam logic [1:0] LANE_CB = 2'd1;
   localparam logic [1:0] LANE_Y1 = 2'd2;
   localparam logic [1:0] LANE_CR = 2'd3;

   // Frame geometry shared with the downstream shift stages so EOF/EOL agree
   localparam int FRM_COL_DEF = 640;
   localparam int FRM_ROW_DEF = 400;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FRAME = 2'd2
   } state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with async active-low clear
module sync_fifo_fwft #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   // Flags, qualified strobes and next pointers; a read frees the slot a full write lands in
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since empty masks the head
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ycbcr_stream_packer.sv
// rtl/ycbcr_stream_packer.sv - camera bytes to tagged 36-bit YCbCr422 words; PACK_TEST_PATTERN_EN adds tp_en pattern source
module ycbcr_stream_packer
   import ycbcr_stream_packer_pkg::*;
#(
   parameter int FRM_COL    = FRM_COL_DEF,
   parameter int FRM_ROW    = FRM_ROW_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cam_fv,
   input  logic             cam_lv,
   input  logic             cam_vld,
   input  logic [7:0]       cam_data,
`ifdef PACK_TEST_PATTERN_EN
   input  logic             tp_en,
`endif
   output logic             vld_o,
   input  logic             ds_rdy,
   output logic [DSIZE-1:0] dout,
   output logic             ovf_err,
   output logic             line_err,
   output logic             frm_err
);

   localparam int WPL = FRM_COL / 2;
   localparam int WW  = $clog2(WPL + 1);
   localparam int LW  = $clog2(FRM_ROW + 1);
   // word_cnt saturates at W_FULL (line complete), line_cnt at L_FULL (extra lines)
   localparam logic [WW-1:0] W_LAST = WW'(WPL - 1);
   localparam logic [WW-1:0] W_FULL = WW'(WPL);
   localparam logic [LW-1:0] L_LAST = LW'(FRM_ROW - 1);
   localparam logic [LW-1:0] L_FULL = LW'(FRM_ROW);

   state_e           state_q, state_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [WW-1:0]    word_cnt_q, word_cnt_d;
   logic [LW-1:0]    line_cnt_q, line_cnt_d;
   logic [23:0]      shift_q, shift_d;
   logic             lv_q, lv_d;
   logic             eof_seen_q, eof_seen_d;
   logic             wr_pend_q, wr_pend_d;
   logic [DSIZE-1:0] wr_word_q, wr_word_d;
   logic             ovf_err_q, ovf_err_d;
   logic             line_err_q, line_err_d;
   logic             frm_err_q, frm_err_d;
   logic [7:0]       byte_in;
   logic             sol, eol, sof, eof;
   logic             fifo_full, fifo_empty, fifo_rd;

`ifdef PACK_TEST_PATTERN_EN
   logic tp_s1_q, tp_s2_q, tp_mode_q, tp_mode_d;

   // Pattern mode only changes when a new frame starts
   always_comb begin
      tp_mode_d = tp_mode_q;
      if (state_q == ST_ARMED && cam_fv) tp_mode_d = tp_s2_q;
   end

   // tp_en synchronizer and latched mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tp_s1_q   <= 1'b0;
         tp_s2_q   <= 1'b0;
         tp_mode_q <= 1'b0;
      end else begin
         tp_s1_q   <= tp_en;
         tp_s2_q   <= tp_s1_q;
         tp_mode_q <= tp_mode_d;
      end
   end

   // Byte source: camera or generated pattern selected per lane
   always_comb begin
      byte_in = cam_data;
      if (tp_mode_q) begin
         case (byte_cnt_q)
            LANE_Y0, LANE_Y1: byte_in = 8'(word_cnt_q);
            LANE_CB:          byte_in = 8'h80;
            default:          byte_in = 8'(line_cnt_q);
         endcase
      end
   end
`else
   // Byte source: camera data passes straight through
   always_comb begin
      byte_in = cam_data;
   end
`endif

   // Sideband tags for the word being completed this cycle
   always_comb begin
      sol = (word_cnt_q == '0);
      eol = (word_cnt_q == W_LAST);
      sof = sol && (line_cnt_q == '0);
      eof = eol && (line_cnt_q == L_LAST);
   end

   assign fifo_rd = vld_o && ds_rdy;

   // Frame FSM, lane packing, counters and sticky error detection
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      line_cnt_d = line_cnt_q;
      shift_d    = shift_q;
      lv_d       = cam_lv;
      eof_seen_d = eof_seen_q;
      wr_pend_d  = 1'b0;
      wr_word_d  = wr_word_q;
      ovf_err_d  = ovf_err_q;
      line_err_d = line_err_q;
      frm_err_d  = frm_err_q;

      if (wr_pend_q && fifo_full && !fifo_rd) ovf_err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!cam_fv) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (cam_fv) begin
               state_d    = ST_FRAME;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               line_cnt_d = '0;
               eof_seen_d = 1'b0;
            end
         end
         ST_FRAME: begin
            if (cam_fv && cam_lv && cam_vld) begin
               if (line_cnt_q == L_FULL) begin
                  frm_err_d = 1'b1;
               end else if (word_cnt_q == W_FULL) begin
                  line_err_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     LANE_Y0: shift_d[7:0]   = byte_in;
                     LANE_CB: shift_d[15:8]  = byte_in;
                     LANE_Y1: shift_d[23:16] = byte_in;
                     default: begin
                        wr_pend_d         = 1'b1;
                        wr_word_d         = {4'b0000, byte_in, shift_q};
                        wr_word_d[SB_SOF] = sof;
                        wr_word_d[SB_EOF] = eof;
                        wr_word_d[SB_SOL] = sol;
                        wr_word_d[SB_EOL] = eol;
                        word_cnt_d        = word_cnt_q + WW'(1);
                        if (eof) eof_seen_d = 1'b1;
                     end
                  endcase
               end
            end
            if (lv_q && !cam_lv) begin
               byte_cnt_d = '0;
               word_cnt_d = '0;
               if (line_cnt_q != L_FULL) begin
                  if (byte_cnt_q != 2'd0 || word_cnt_q != W_FULL) line_err_d = 1'b1;
                  line_cnt_d = line_cnt_q + LW'(1);
               end
            end
            if (!cam_fv) begin
               state_d = ST_ARMED;
               if (!eof_seen_q) frm_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         line_cnt_q <= '0;
         shift_q    <= '0;
         lv_q       <= 1'b0;
         eof_seen_q <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_word_q  <= '0;
         ovf_err_q  <= 1'b0;
         line_err_q <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         line_cnt_q <= line_cnt_d;
         shift_q    <= shift_d;
         lv_q       <= lv_d;
         eof_seen_q <= eof_seen_d;
         wr_pend_q  <= wr_pend_d;
         wr_word_q  <= wr_word_d;
         ovf_err_q  <= ovf_err_d;
         line_err_q <= line_err_d;
         frm_err_q  <= frm_err_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (DSIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_pend_q),
      .wr_data (wr_word_q),
      .full    (fifo_full),
      .rd_en   (fifo_rd),
      .rd_data (dout),
      .empty   (fifo_empty)
   );

   assign vld_o    = !fifo_empty;
   assign ovf_err  = ovf_err_q;
   assign line_err = line_err_q;
   assign frm_err  = frm_err_q;

endmodule
